// File: rtl/prio_encoder8to3_req.sv
`default_nettype none
// ============================================================================
// Module   : prio_encoder8to3_req
// Purpose  : Sequential 8-to-3 priority encoder.
//            - Captures single-cycle request pulses into a sticky pending
//              register.
//            - Presents the index of the highest-priority pending line over
//              a valid/ready handshake.
//            - Clears that line once it has been served.
// Ports    : clk       - single clock, rising-edge active
//            rst_n     - asynchronous active-low reset
//            in[7:0]   - request pulses, bit i sets pending bit i
//            out[2:0]  - binary index of the presented request
//            out_valid - out holds a valid request index
//            out_ready - consumer accepts out this cycle
//            pending   - registered pending vector
//            pend_cnt  - number of set bits in pending (0..8)
//            overrun   - 1-cycle pulse, request hit an already-pending bit
// Params   : HIGH_FIRST - 1: bit 7 highest priority, 0: bit 0 highest
// Revision : 1.0 - initial release
// ============================================================================
module prio_encoder8to3_req #(
  parameter int HIGH_FIRST = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in,
  output logic [2:0] out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] pending,
  output logic [3:0] pend_cnt,
  output logic       overrun
);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic [2:0] r_out;
  logic [2:0] w_out_next;
  logic [7:0] r_pending;
  logic [3:0] r_pend_cnt;
  logic       r_overrun;

  logic       w_transfer;
  logic [7:0] w_served;
  logic [7:0] w_rem;
  logic [7:0] w_pend_next;
  logic       w_overrun_next;

  // Priority pick. The scan direction is chosen so that the last set bit
  // visited is the winner, which keeps the loop free of early exits.
  function automatic logic [2:0] f_prio(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    if (HIGH_FIRST != 0) begin
      for (int i = 0; i < 8; i++) begin
        if (v[i]) idx = 3'(i);
      end
    end else begin
      for (int i = 7; i >= 0; i--) begin
        if (v[i]) idx = 3'(i);
      end
    end
    return idx;
  endfunction

  function automatic logic [3:0] f_popcnt(input logic [7:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'd0, v[i]};
    end
    return c;
  endfunction

  assign w_transfer     = (r_state == ST_PRESENT) && out_ready;
  assign w_served       = w_transfer ? (8'h01 << r_out) : 8'h00;
  assign w_rem          = r_pending & ~w_served;
  // OR-ing in after the clear lets a same-edge re-request win over service.
  assign w_pend_next    = w_rem | in;
  assign w_overrun_next = |(in & r_pending & ~w_served);

  // Selection only looks at registered pending (or its served remainder),
  // so requests landing on this edge wait one cycle, and a held code is
  // never replaced by a newer higher-priority request.
  always_comb begin
    w_state_next = r_state;
    w_out_next   = r_out;
    case (r_state)
      ST_IDLE: begin
        if (r_pending != 8'h00) begin
          w_out_next   = f_prio(r_pending);
          w_state_next = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (w_transfer) begin
          if (w_rem != 8'h00) begin
            w_out_next = f_prio(w_rem);
          end else begin
            w_state_next = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_out      <= 3'd0;
      r_pending  <= 8'h00;
      r_pend_cnt <= 4'd0;
      r_overrun  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_out      <= w_out_next;
      r_pending  <= w_pend_next;
      r_pend_cnt <= f_popcnt(w_pend_next);
      r_overrun  <= w_overrun_next;
    end
  end

  assign out       = r_out;
  assign out_valid = (r_state == ST_PRESENT);
  assign pending   = r_pending;
  assign pend_cnt  = r_pend_cnt;
  assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_prio_encoder8to3_req.sv
`default_nettype none
// ============================================================================
// Module   : tb_prio_encoder8to3_req
// Purpose  : Self-checking bench for prio_encoder8to3_req. Two instances
//            (HIGH_FIRST=1 and HIGH_FIRST=0) share one stimulus stream and
//            are compared each cycle against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prio_encoder8to3_req;

  logic       clk;
  logic       rst_n;
  logic [7:0] in;
  logic       out_ready;

  logic [2:0] out_h,     out_l;
  logic       valid_h,   valid_l;
  logic [7:0] pend_h,    pend_l;
  logic [3:0] cnt_h,     cnt_l;
  logic       ovr_h,     ovr_l;

  int n_checks;
  int n_fail;

  // Model state, index 0 = HIGH_FIRST=1, index 1 = HIGH_FIRST=0
  logic [7:0] m_pend  [2];
  int         m_out   [2];
  bit         m_valid [2];
  bit         m_ovr   [2];

  prio_encoder8to3_req #(.HIGH_FIRST(1)) dut_h (
    .clk(clk), .rst_n(rst_n), .in(in), .out(out_h), .out_valid(valid_h),
    .out_ready(out_ready), .pending(pend_h), .pend_cnt(cnt_h), .overrun(ovr_h)
  );

  prio_encoder8to3_req #(.HIGH_FIRST(0)) dut_l (
    .clk(clk), .rst_n(rst_n), .in(in), .out(out_l), .out_valid(valid_l),
    .out_ready(out_ready), .pending(pend_l), .pend_cnt(cnt_l), .overrun(ovr_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Index of the winning request: scan from the top-priority end.
  function automatic int pick(input logic [7:0] v, input int k);
    if (k == 0) begin
      for (int i = 7; i >= 0; i--) if (v[i]) return i;
    end else begin
      for (int i = 0; i < 8; i++) if (v[i]) return i;
    end
    return 0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pend[k] = 8'h00; m_out[k] = 0; m_valid[k] = 0; m_ovr[k] = 0;
    end
  endtask

  task automatic check_model();
    chk("pend_h",  32'(pend_h),  32'(m_pend[0]));
    chk("valid_h", 32'(valid_h), 32'(m_valid[0]));
    chk("cnt_h",   32'(cnt_h),   32'($countones(m_pend[0])));
    chk("ovr_h",   32'(ovr_h),   32'(m_ovr[0]));
    if (m_valid[0]) chk("out_h", 32'(out_h), 32'(m_out[0]));
    chk("pend_l",  32'(pend_l),  32'(m_pend[1]));
    chk("valid_l", 32'(valid_l), 32'(m_valid[1]));
    chk("cnt_l",   32'(cnt_l),   32'($countones(m_pend[1])));
    chk("ovr_l",   32'(ovr_l),   32'(m_ovr[1]));
    if (m_valid[1]) chk("out_l", 32'(out_l), 32'(m_out[1]));
  endtask

  // One clock: drive inputs, advance the model over the edge, check at negedge.
  task automatic cycle(input logic [7:0] req, input logic rdy);
    logic [7:0] served, rem;
    logic [7:0] n_pend [2];
    int         n_out  [2];
    bit         n_val  [2];
    bit         n_ovr  [2];
    in = req;
    out_ready = rdy;
    for (int k = 0; k < 2; k++) begin
      served   = (m_valid[k] && rdy) ? (8'h01 << m_out[k]) : 8'h00;
      rem      = m_pend[k] & ~served;
      n_pend[k] = rem | req;
      n_ovr[k]  = |(req & rem);
      n_out[k]  = m_out[k];
      n_val[k]  = m_valid[k];
      if (!m_valid[k]) begin
        if (m_pend[k] != 0) begin n_out[k] = pick(m_pend[k], k); n_val[k] = 1; end
      end else if (rdy) begin
        if (rem != 0) n_out[k] = pick(rem, k);
        else          n_val[k] = 0;
      end
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      m_pend[k] = n_pend[k]; m_out[k] = n_out[k];
      m_valid[k] = n_val[k]; m_ovr[k] = n_ovr[k];
    end
    @(negedge clk);
    check_model();
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    in = 8'h00;
    out_ready = 1'b0;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_pend",  32'(pend_h),  32'h00);
    chk("rst_valid", 32'(valid_h), 32'h0);
    chk("rst_out",   32'(out_h),   32'h0);
    chk("rst_cnt",   32'(cnt_l),   32'h0);
    chk("rst_ovr",   32'(ovr_l),   32'h0);
    rst_n = 1'b1;

    // Single request, latency 1 to pending, 2 to out_valid
    cycle(8'h20, 1'b0);
    chk("single_pend", 32'(pend_h), 32'h20);
    chk("single_nv",   32'(valid_h), 32'h0);
    cycle(8'h00, 1'b0);
    chk("single_out",  32'(out_h), 32'd5);
    chk("single_val",  32'(valid_h), 32'h1);
    cycle(8'h00, 1'b1);
    chk("single_done", 32'(valid_h), 32'h0);
    chk("single_clr",  32'(pend_h), 32'h00);

    // Drain of 8'b1000_0101 with ready held
    cycle(8'h85, 1'b1);
    chk("drain_cnt3", 32'(cnt_h), 32'd3);
    cycle(8'h00, 1'b1);
    chk("drain_h0", 32'(out_h), 32'd7);
    chk("drain_l0", 32'(out_l), 32'd0);
    cycle(8'h00, 1'b1);
    chk("drain_h1", 32'(out_h), 32'd2);
    chk("drain_l1", 32'(out_l), 32'd2);
    chk("drain_cnt2", 32'(cnt_h), 32'd2);
    cycle(8'h00, 1'b1);
    chk("drain_h2", 32'(out_h), 32'd0);
    chk("drain_l2", 32'(out_l), 32'd7);
    chk("drain_cnt1", 32'(cnt_l), 32'd1);
    cycle(8'h00, 1'b1);
    chk("drain_idle", 32'(valid_h), 32'h0);
    chk("drain_cnt0", 32'(cnt_h), 32'd0);

    // Backpressure: code 3 held while a higher-priority request arrives
    cycle(8'h08, 1'b0);
    cycle(8'h00, 1'b0);
    chk("bp_out3", 32'(out_h), 32'd3);
    cycle(8'h80, 1'b0);
    chk("bp_hold", 32'(out_h), 32'd3);
    cycle(8'h00, 1'b0);
    chk("bp_hold2", 32'(out_h), 32'd3);
    chk("bp_val",   32'(valid_h), 32'h1);
    cycle(8'h00, 1'b1);
    chk("bp_next7", 32'(out_h), 32'd7);
    cycle(8'h00, 1'b1);

    // Set and serve on the same edge
    cycle(8'h10, 1'b0);
    cycle(8'h00, 1'b0);
    chk("col_out4", 32'(out_h), 32'd4);
    cycle(8'h10, 1'b1);
    chk("col_pend", 32'(pend_h), 32'h10);
    chk("col_ovr",  32'(ovr_h), 32'h0);
    cycle(8'h00, 1'b0);
    chk("col_again", 32'(out_h), 32'd4);
    chk("col_val",   32'(valid_h), 32'h1);
    cycle(8'h00, 1'b1);

    // Overrun pulse
    cycle(8'h01, 1'b0);
    cycle(8'h01, 1'b0);
    chk("ovr_pulse", 32'(ovr_h), 32'h1);
    chk("ovr_cnt",   32'(cnt_h), 32'd1);
    cycle(8'h00, 1'b0);
    chk("ovr_end",   32'(ovr_h), 32'h0);
    cycle(8'h00, 1'b1);

    // Randomized traffic against the model
    for (int n = 0; n < 300; n++) begin
      logic [7:0] r;
      r = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      cycle(r, 1'($urandom_range(0, 1)));
    end

    // Full pending then asynchronous reset between edges
    cycle(8'hFF, 1'b0);
    cycle(8'hFF, 1'b0);
    chk("full_cnt", 32'(cnt_h), 32'd8);
    chk("full_val", 32'(valid_l), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_pend_h", 32'(pend_h),  32'h00);
    chk("arst_val_h",  32'(valid_h), 32'h0);
    chk("arst_cnt_h",  32'(cnt_h),   32'h0);
    chk("arst_pend_l", 32'(pend_l),  32'h00);
    chk("arst_val_l",  32'(valid_l), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 40; n++) begin
      logic [7:0] r;
      r = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      cycle(r, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
